// File: rtl/display_scan_mux_pkg.sv
// Shared constants for the 7-segment scan display blocks.
package display_scan_mux_pkg;

  localparam int NIB_W        = 4;
  localparam int MAX_DIGITS   = 8;
  localparam int N_DIGITS_DEF = 8;

  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: pcnt counts 0..DIV-1, tick marks the last count.
module tick_gen #(
  parameter int DIV = 100000,
  parameter int W   = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic         clk,
  input  logic         reset,
  output logic         tick_o,
  output logic [W-1:0] pcnt_o
);

  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] pcnt_q;
  logic [W-1:0] pcnt_d;

  assign tick_o = (pcnt_q == LAST);
  assign pcnt_d = tick_o ? '0 : pcnt_q + 1'b1;
  assign pcnt_o = pcnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed digit scanner: double-buffered word, leading-zero suppression,
// blanking at the head of each slot to stop ghosting between digits.
module display_scan_mux
  import display_scan_mux_pkg::*;
#(
  parameter int N_DIGITS    = N_DIGITS_DEF,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NIB_W*N_DIGITS-1:0] value_in,
  input  logic                      load,
  input  logic [N_DIGITS-1:0]       dp_in,
  input  logic                      lz_en,
  output logic [NIB_W-1:0]          bcd_out,
  output logic [N_DIGITS-1:0]       anode_out,
  output logic                      dp_out,
  output logic                      frame_start
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);

  localparam logic [PW-1:0] BLANK_P  = PW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  logic          tick;
  logic [PW-1:0] pcnt;

  tick_gen #(
    .DIV (REFRESH_DIV),
    .W   (PW)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .tick_o (tick),
    .pcnt_o (pcnt)
  );

  logic [N_DIGITS-1:0][NIB_W-1:0] shd_val_q, disp_val_q;
  logic [N_DIGITS-1:0]            shd_dp_q, disp_dp_q;
  logic                           shd_lz_q, disp_lz_q;
  logic [IW-1:0]                  idx_q, idx_d;

  logic [NIB_W-1:0]    bcd_q;
  logic [N_DIGITS-1:0] anode_q, anode_d;
  logic                dp_q, dp_d;
  logic                fs_q;

  logic          frame_end;
  logic [IW-1:0] msd;
  logic          suppress;
  logic          blank;

  assign frame_end = tick && (idx_q == IDX_LAST);
  assign idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

  // Scanning upward leaves the highest nonzero digit in msd.
  always_comb begin
    msd = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (disp_val_q[k] != '0) msd = IW'(k);
    end
  end

  assign suppress = disp_lz_q && (idx_q > msd) && !disp_dp_q[idx_q];
  assign blank    = (pcnt < BLANK_P) || suppress;

  always_comb begin
    anode_d = ANODE_OFF[N_DIGITS-1:0];
    if (!blank) anode_d[idx_q] = 1'b0;
  end

  assign dp_d = blank | ~disp_dp_q[idx_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      shd_val_q  <= '0;
      shd_dp_q   <= '0;
      shd_lz_q   <= 1'b0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      disp_lz_q  <= 1'b0;
      idx_q      <= '0;
      bcd_q      <= '0;
      anode_q    <= ANODE_OFF[N_DIGITS-1:0];
      dp_q       <= 1'b1;
      fs_q       <= 1'b0;
    end else begin
      if (load) begin
        shd_val_q <= value_in;
        shd_dp_q  <= dp_in;
        shd_lz_q  <= lz_en;
      end
      // A load on the boundary cycle bypasses the shadow so it is not lost a frame.
      if (frame_end) begin
        disp_val_q <= load ? value_in : shd_val_q;
        disp_dp_q  <= load ? dp_in    : shd_dp_q;
        disp_lz_q  <= load ? lz_en    : shd_lz_q;
      end
      if (tick) idx_q <= idx_d;
      bcd_q   <= disp_val_q[idx_q];
      anode_q <= anode_d;
      dp_q    <= dp_d;
      fs_q    <= (pcnt == '0) && (idx_q == '0);
    end
  end

  assign bcd_out     = bcd_q;
  assign anode_out   = anode_q;
  assign dp_out      = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with N_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2.
module tb_display_scan_mux;

  logic        clk;
  logic        reset;
  logic [15:0] value_in;
  logic        load;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic [3:0]  bcd_out;
  logic [3:0]  anode_out;
  logic        dp_out;
  logic        frame_start;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  display_scan_mux #(
    .N_DIGITS    (4),
    .REFRESH_DIV (8),
    .BLANK_CYC   (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .value_in    (value_in),
    .load        (load),
    .dp_in       (dp_in),
    .lz_en       (lz_en),
    .bcd_out     (bcd_out),
    .anode_out   (anode_out),
    .dp_out      (dp_out),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc = number of rising edges since reset was released
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic at(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != c) check("sync", cyc, c);
  endtask

  task automatic chk_slot(input string tag, input int c, input logic [3:0] an,
                          input logic [3:0] bcd, input logic dp);
    at(c);
    check({tag, "_anode"}, anode_out, an);
    check({tag, "_bcd"}, bcd_out, bcd);
    check({tag, "_dp"}, dp_out, dp);
  endtask

  task automatic do_load(input int c, input logic [15:0] v, input logic [3:0] dp, input logic lz);
    at(c);
    value_in = v;
    dp_in    = dp;
    lz_en    = lz;
    load     = 1'b1;
    at(c + 1);
    load     = 1'b0;
    dp_in    = '0;
    lz_en    = 1'b0;
    value_in = 16'hFFFF;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    value_in = '0;
    dp_in    = '0;
    lz_en    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_anode", anode_out, 4'b1111);
    check("rst_bcd", bcd_out, 4'h0);
    check("rst_dp", dp_out, 1'b1);
    check("rst_fs", frame_start, 1'b0);
    reset = 1'b0;

    // Scan order: frame 0 shows zeros, 4321 appears at frame 1 (cycle 33)
    at(1);
    check("fs_c1", frame_start, 1'b1);
    do_load(1, 16'h4321, 4'b0000, 1'b0);
    chk_slot("f0_blank", 2, 4'b1111, 4'h0, 1'b1);
    chk_slot("f0_d0", 3, 4'b1110, 4'h0, 1'b1);
    at(33);
    check("fs_c33", frame_start, 1'b1);
    check("d0_blank_bcd", bcd_out, 4'h1);
    check("d0_blank_anode", anode_out, 4'b1111);
    at(34);
    check("fs_c34", frame_start, 1'b0);
    check("d0_blank2_anode", anode_out, 4'b1111);
    chk_slot("d0_first", 35, 4'b1110, 4'h1, 1'b1);
    chk_slot("d0_last", 40, 4'b1110, 4'h1, 1'b1);
    chk_slot("d1_blank", 41, 4'b1111, 4'h2, 1'b1);

    // Tear-free: load at digit-1 slot start, rest of frame keeps 4321
    do_load(41, 16'hAAAA, 4'b0000, 1'b0);
    chk_slot("d1_act", 43, 4'b1101, 4'h2, 1'b1);
    chk_slot("d2_act", 51, 4'b1011, 4'h3, 1'b1);
    chk_slot("d3_act", 59, 4'b0111, 4'h4, 1'b1);
    chk_slot("new_d0", 67, 4'b1110, 4'hA, 1'b1);
    do_load(70, 16'h1111, 4'b0000, 1'b0);
    chk_slot("old_d3", 95, 4'b0111, 4'hA, 1'b1);
    // Boundary-coincident load overrides the earlier shadow load
    do_load(95, 16'h5678, 4'b0000, 1'b0);
    at(97);
    check("byp_fs", frame_start, 1'b1);
    check("byp_bcd", bcd_out, 4'h8);
    chk_slot("byp_d1", 107, 4'b1101, 4'h7, 1'b1);

    // Leading-zero suppression
    do_load(110, 16'h0050, 4'b0000, 1'b1);
    chk_slot("lz_d0", 131, 4'b1110, 4'h0, 1'b1);
    chk_slot("lz_d1", 139, 4'b1101, 4'h5, 1'b1);
    chk_slot("lz_d2", 147, 4'b1111, 4'h0, 1'b1);
    chk_slot("lz_d3", 155, 4'b1111, 4'h0, 1'b1);
    do_load(157, 16'h0000, 4'b0000, 1'b1);
    chk_slot("lz0_d0", 163, 4'b1110, 4'h0, 1'b1);
    chk_slot("lz0_d1", 171, 4'b1111, 4'h0, 1'b1);

    // Decimal point protects a zero digit from suppression
    do_load(173, 16'h0007, 4'b0100, 1'b1);
    chk_slot("dp_d0", 195, 4'b1110, 4'h7, 1'b1);
    chk_slot("dp_d1", 203, 4'b1111, 4'h0, 1'b1);
    chk_slot("dp_d2", 211, 4'b1011, 4'h0, 1'b0);
    chk_slot("dp_d3", 219, 4'b1111, 4'h0, 1'b1);

    // Reset in the middle of the digit-2 slot
    chk_slot("pre_rst_d2", 243, 4'b1011, 4'h0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_anode", anode_out, 4'b1111);
    check("mid_rst_bcd", bcd_out, 4'h0);
    check("mid_rst_dp", dp_out, 1'b1);
    check("mid_rst_fs", frame_start, 1'b0);
    reset = 1'b0;
    at(1);
    check("rst2_fs", frame_start, 1'b1);
    chk_slot("rst2_blank", 2, 4'b1111, 4'h0, 1'b1);
    chk_slot("rst2_d0", 3, 4'b1110, 4'h0, 1'b1);
    chk_slot("rst2_d1", 11, 4'b1101, 4'h0, 1'b1);
    at(33);
    check("rst2_fs33", frame_start, 1'b1);
    chk_slot("rst2_shadow", 35, 4'b1110, 4'h0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
